condition_handler: RTL
======================

# condition_handler

Branch-resolution and condition-evaluation block for the ID stage. It owns the NZCV status register, written from the EX-stage ALU flags when the EX instruction has S set. It evaluates the 4-bit condition field of the instruction currently in IF/ID against those flags, forwarding the EX flags when needed. From the result it drives three controls: the NOP select of the CU mux (cond-false or squashed instructions become bubbles in ID/EX), the PC-source select for taken B/BL, and the IF/ID flush.

## Interface
- No parameters.
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Clr  in  1  reset; one clock; reset is asynchronous and active-low.
- ID_cond  in  4  condition field (I31_28) of instruction in IF/ID.
- ID_B_instr  in  1  B decoded by control unit for the ID instruction.
- ID_BL_instr  in  1  BL decoded by control unit for the ID instruction.
- EX_S  in  1  S bit of instruction in ID/EX (already zero if that slot is a bubble).
- ALU_flags  in  4  {N,Z,C,V} produced by EX-stage ALU this cycle.
- flags_q  out  4  architectural {N,Z,C,V} register.
- cond_true  out  1  ID instruction's condition passes and it is not squashed.
- nop_sel  out  1  to CU mux select; 1 forces all control outputs to zero.
- branch_taken  out  1  PC-source select: 1 loads branch target instead of PC+4.
- link_write  out  1  taken BL; request R14 <- ID next-PC.
- if_id_flush  out  1  clear IF/ID on next edge.
- branch_count  out  8  number of taken branches since reset.

## Operation
- Effective flags eff = EX_S ? ALU_flags : flags_q. Forwarding has priority over the register.
- Condition decode on eff (N,Z,C,V):
  - Basic conditions: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - Combined conditions: 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 NV 0.
- Squash register squash_q: set on an edge where branch_taken=1, cleared on every other edge. It marks the ID slot holding the flushed fall-through instruction. This is required because a cleared IF/ID word (0x00000000) decodes as ANDEQ and would otherwise execute when Z=1.
- cond_true = pass(ID_cond, eff) & ~squash_q.
- nop_sel = ~cond_true.
- branch_taken = cond_true & (ID_B_instr | ID_BL_instr).
- link_write = cond_true & ID_BL_instr.
- if_id_flush = branch_taken.
- Flags register: flags_q <= ALU_flags on an edge where EX_S=1; otherwise it holds.
- branch_count: +1 on each edge with branch_taken=1. 8-bit, wraps 255 -> 0.
- A conditional branch immediately following a CMP/S instruction resolves on that instruction's flags in the same cycle, with zero stall.

## Timing
- Reset (Clr=0, asynchronous): flags_q=0000, squash_q=0, branch_count=0.
  - Outputs during reset follow the comb equations with flags_q=0: NE/CC/PL/VC/GE/GT/AL pass, EQ/CS/MI/VS/LT/LE/HI/NV fail.
- Reset asserted mid-operation: all state clears immediately and no update occurs on any edge while Clr=0. On the first edge after release, normal updates resume.
- All outputs except flags_q and branch_count are combinational from inputs, flags_q and squash_q. Zero-cycle latency to the CU mux, PC mux and IF/ID.
- Flag update latency: flags written by EX at edge k are visible in flags_q after edge k. They are visible to ID via forwarding in the cycle before edge k.
- Taken branch in cycle k:
  - Edge k: PC loads target, IF/ID flushes, squash_q=1.
  - Cycle k+1: nop_sel=1, branch_taken=0 regardless of ID contents.
  - Edge k+1: squash_q returns to 0.
- Back-to-back branches: the second is always squashed. A branch in the squashed slot never takes and never increments branch_count.
- Simultaneous EX_S=1 and taken branch in ID: the flags update and the branch both happen on the same edge, with the condition evaluated on forwarded ALU_flags.
- Cond false on a B/BL: nop_sel=1, branch_taken=0, no flush, squash_q stays 0.

## Test plan
- Reset: hold Clr=0, drive ALU_flags=1111 and EX_S=1, toggle Clk -> flags_q=0000, branch_count=0. Release Clr, one edge -> flags_q=1111.
- Forwarding: flags_q=0000, EX_S=1, ALU_flags=0100 (Z), ID_cond=0000, ID_B_instr=1 -> cond_true=1, branch_taken=1, if_id_flush=1. After edge: flags_q=0100, branch_count=1.
- Squash: after the taken branch above, ID_cond=0000, ID_B_instr=1, Z=1 -> nop_sel=1, branch_taken=0, branch_count stays 1. Next cycle same inputs -> branch_taken=1.
- Signed conditions: flags_q=1000 (N, V=0), EX_S=0 -> LT passes, GE fails, GT fails, LE passes. Flags 1001 -> GE and GT pass.
- AL/NV and BL: ID_cond=1110, ID_BL_instr=1 -> link_write=1, branch_taken=1. ID_cond=1111 -> nop_sel=1, link_write=0.
- Counter wrap: 256 taken branches separated by non-branch cycles -> branch_count returns to 0. Assert Clr=0 mid-sequence -> counter resets to 0 immediately, asynchronously.

Source files
------------

// File: rtl/condition_handler.sv
// condition_handler: ID-stage condition evaluation and branch resolution.
// Owns the NZCV register. It evaluates the IF/ID condition field against the
// EX flags when the EX instruction has S set, and against the register
// otherwise. It drives the CU NOP select, the PC-source select and the IF/ID
// flush.
//
// Ports:
//   Clk          pipeline clock, rising edge
//   Clr          asynchronous active-low reset
//   ID_cond      condition field of the IF/ID instruction
//   ID_B_instr   B decoded for the ID instruction
//   ID_BL_instr  BL decoded for the ID instruction
//   EX_S         S bit of the ID/EX instruction
//   ALU_flags    {N,Z,C,V} from the EX-stage ALU
//   flags_q      architectural {N,Z,C,V} (registered)
//   cond_true    ID condition passes and the slot is not squashed
//   nop_sel      CU mux bubble select
//   branch_taken PC-source select for taken B/BL
//   link_write   taken BL, write R14
//   if_id_flush  clear IF/ID on next edge
//   branch_count taken branches since reset (registered, wraps)
module condition_handler (
    input  logic       Clk,
    input  logic       Clr,
    input  logic [3:0] ID_cond,
    input  logic       ID_B_instr,
    input  logic       ID_BL_instr,
    input  logic       EX_S,
    input  logic [3:0] ALU_flags,
    output logic [3:0] flags_q,
    output logic       cond_true,
    output logic       nop_sel,
    output logic       branch_taken,
    output logic       link_write,
    output logic       if_id_flush,
    output logic [7:0] branch_count
);

    localparam int unsigned CNT_W = 8;

    logic [3:0] eff;
    logic       pass;
    logic       squash_q;
    logic       n_f, z_f, c_f, v_f;

    // Condition evaluation on forwarded or architectural flags
    always_comb begin
        eff  = EX_S ? ALU_flags : flags_q;
        n_f  = eff[3];
        z_f  = eff[2];
        c_f  = eff[1];
        v_f  = eff[0];
        pass = 1'b0;
        case (ID_cond)
            4'b0000: pass = z_f;
            4'b0001: pass = ~z_f;
            4'b0010: pass = c_f;
            4'b0011: pass = ~c_f;
            4'b0100: pass = n_f;
            4'b0101: pass = ~n_f;
            4'b0110: pass = v_f;
            4'b0111: pass = ~v_f;
            4'b1000: pass = c_f & ~z_f;
            4'b1001: pass = ~c_f | z_f;
            4'b1010: pass = (n_f == v_f);
            4'b1011: pass = (n_f != v_f);
            4'b1100: pass = ~z_f & (n_f == v_f);
            4'b1101: pass = z_f | (n_f != v_f);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase

        // squash_q marks the flushed fall-through slot (cleared word decodes as ANDEQ)
        cond_true    = pass & ~squash_q;
        nop_sel      = ~cond_true;
        branch_taken = cond_true & (ID_B_instr | ID_BL_instr);
        link_write   = cond_true & ID_BL_instr;
        if_id_flush  = branch_taken;
    end

    // Flags register, squash marker and taken-branch counter
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            flags_q      <= 4'b0000;
            squash_q     <= 1'b0;
            branch_count <= '0;
        end else begin
            if (EX_S) begin
                flags_q <= ALU_flags;
            end
            squash_q <= branch_taken;
            if (branch_taken) begin
                branch_count <= branch_count + CNT_W'(1);
            end
        end
    end

endmodule
